// File: rtl/div_unit.sv
// Multicycle restoring divider: one trial subtract per cycle, WIDTH+1 cycles from start to result_rdy.
// Optional build macro DIV_SIGNED_EN selects two's-complement operands with sign correction and overflow flag.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken on any rising edge where the unit is IDLE (busy low);
  // result_rdy is a one-cycle pulse, and quotient/remainder/exception hold until the next one.

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
  logic             neg_q, neg_r, dz_r, ovf_r;
  logic             a_neg, b_neg, ovf_in, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  assign a_neg  = dividend[WIDTH-1];
  assign b_neg  = divisor[WIDTH-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor  : divisor;
  assign ovf_in = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`else
  assign a_neg  = 1'b0;
  assign b_neg  = 1'b0;
  assign a_mag  = dividend;
  assign b_mag  = divisor;
  assign ovf_in = 1'b0;
`endif

  // The partial remainder is always below the divisor, so one extra bit holds the shifted value.
  assign shifted = {rem_r, quo_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_r};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? FIX : CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // A divide-by-zero passes through FIX directly, carrying the raw dividend in quo_r.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvsr_r     <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz_r       <= 1'b0;
      ovf_r      <= 1'b0;
      result_rdy <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      exception  <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dvsr_r <= b_mag;
          rem_r  <= '0;
          count  <= '0;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          ovf_r  <= ovf_in;
          dz_r   <= div_zero;
          quo_r  <= div_zero ? dividend : a_mag;
        end
        CALC: begin
          count <= count + CW'(1);
          if (!trial[WIDTH]) begin
            rem_r <= trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          result_rdy <= 1'b1;
          if (dz_r) begin
            quotient  <= '0;
            remainder <= quo_r;
            exception <= 1'b1;
          end else begin
            quotient  <= neg_q ? -quo_r : quo_r;
            remainder <= neg_r ? -rem_r : rem_r;
            exception <= ovf_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results and arrival cycles are queued at issue and
// compared by an independent monitor whenever result_rdy pulses.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, result_rdy, exception;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   state_dbg;

  div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .result_rdy(result_rdy),
    .quotient(quotient), .remainder(remainder),
    .exception(exception), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_e_q[$];
  int           exp_t_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division from the architectural rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic e);
    if (b == 0) begin
      q = 0; r = a; e = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0; e = 1'b1;
      end else begin
        q = sa / sb; r = sa % sb; e = 1'b0;
      end
`else
      q = a / b; r = a % b; e = 1'b0;
`endif
    end
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int t);
    logic [W-1:0] q, r;
    logic e;
    model(a, b, q, r, e);
    exp_q.push_back(q);
    exp_r_q.push_back(r);
    exp_e_q.push_back(e);
    exp_t_q.push_back(t);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n && result_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdy: got result_rdy=1 with q=%h r=%h, required none", quotient, remainder);
      end else begin
        check("quotient",  quotient,  exp_q.pop_front());
        check("remainder", remainder, exp_r_q.pop_front());
        check("exception", W'(exception), W'(exp_e_q.pop_front()));
        check("rdy_cycle", W'(cyc), W'(exp_t_q.pop_front()));
        check("busy_at_rdy", W'(busy), W'(0));
      end
    end
  end

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    start = 1'b1; dividend = a; divisor = b;
    t = cyc + 1 + ((b == 0) ? 1 : LAT);
    push_exp(a, b, t);
    @(negedge clock);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    check("busy_after_start", W'(busy), W'(1));
    while (cyc < t) @(negedge clock);
  endtask

  // start held high for the whole divide while the operands keep changing.
  task automatic held_start(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] a2, input logic [W-1:0] b2);
    int t1, t2;
    start = 1'b1; dividend = a; divisor = b;
    t1 = cyc + 1 + LAT;
    push_exp(a, b, t1);
    do begin
      @(negedge clock);
      if (cyc == t1) begin
        dividend = a2; divisor = b2;
        t2 = cyc + 1 + LAT;
        push_exp(a2, b2, t2);
      end else begin
        dividend = $urandom; divisor = $urandom;
      end
    end while (cyc < t1);
    @(negedge clock);
    start = 1'b0;
    while (cyc < t2) @(negedge clock);
  endtask

  task automatic abort_by_reset();
    start = 1'b1; dividend = 32'h0000_1234; divisor = 32'h11;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy",      W'(busy),       W'(0));
    check("abort_rdy",       W'(result_rdy), W'(0));
    check("abort_quotient",  quotient,       W'(0));
    check("abort_remainder", remainder,      W'(0));
    check("abort_exception", W'(exception),  W'(0));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    int sel;
    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clock);
    check("reset_busy",      W'(busy),       W'(0));
    check("reset_rdy",       W'(result_rdy), W'(0));
    check("reset_quotient",  quotient,       W'(0));
    check("reset_remainder", remainder,      W'(0));
    check("reset_exception", W'(exception),  W'(0));
    check("reset_state",     W'(state_dbg),  W'(0));
    reset_n = 1'b1;
    @(negedge clock);

    do_div(32'd100, 32'd7);
    do_div(32'hFFFF_FF9C, 32'd7);
    do_div(32'h1234_5678, 32'd0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF);
    do_div(32'hFFFF_FFFF, 32'd1);
    do_div(32'd5, 32'd9);
    held_start(32'd50, 32'd5, 32'd77, 32'd6);
    abort_by_reset();
    do_div(32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       b = 32'hFFFF_FFFF;
        5:       b = 1;
        6:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      do_div(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d results still pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
